// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the 2-read / 1-write register file: write port from
// writeback, two read ports from decode, plus status and debug signals.
interface reg_file_2r1w_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    // Handshake: the write port has no valid/ready pair. wr_en is a plain
    // strobe sampled at posedge clk; it is honoured only while ready=1, and
    // a strobe seen while ready=0 is discarded and latched into wr_drop.
    // Read ports are purely combinational, address in -> data out.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  ready;
    logic                  wr_drop;
    logic                  dbg_state;  // 0 = CLEAR, 1 = RUN

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, ready, wr_drop, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, ready, wr_drop, dbg_state
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file with one synchronous write port and two asynchronous read
// ports. After reset a sequencer writes zero to every entry, one per clock,
// before the array accepts writes. Optional hardwired zero entry and
// optional same-cycle write-to-read forwarding.
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_file_2r1w_if.slave     bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wr_drop_q, wr_drop_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    // Next-state: clear sequencer walks every entry, then the write port
    // owns the array. Writes seen during the clear are dropped and flagged.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = wr_drop_q;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (bus.wr_en) begin
                    wr_drop_d = 1'b1;
                end
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                // Entry 0 is read-only when hardwired; discard silently.
                if (bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0)) begin
                    mem_we = 1'b1;
                end
            end
        endcase
    end

    // Control flops: async reset restarts the clear from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage array: not reset, the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port A: zero during clear, then zero-entry, bypass, stored value.
    always_comb begin
        rd_a = mem_q[bus.rd_addr_a];
        if (state_q != ST_RUN) begin
            rd_a = '0;
        end else if (ZERO_REG != 0 && bus.rd_addr_a == '0) begin
            rd_a = '0;
        end else if (BYPASS != 0 && bus.wr_en && bus.wr_addr == bus.rd_addr_a) begin
            rd_a = bus.wr_data;
        end
    end

    // Read port B: same resolution order as port A.
    always_comb begin
        rd_b = mem_q[bus.rd_addr_b];
        if (state_q != ST_RUN) begin
            rd_b = '0;
        end else if (ZERO_REG != 0 && bus.rd_addr_b == '0) begin
            rd_b = '0;
        end else if (BYPASS != 0 && bus.wr_en && bus.wr_addr == bus.rd_addr_b) begin
            rd_b = bus.wr_data;
        end
    end

    assign bus.rd_data_a = rd_a;
    assign bus.rd_data_b = rd_b;
    assign bus.ready     = (state_q == ST_RUN);
    assign bus.wr_drop   = wr_drop_q;
    assign bus.dbg_state = state_q[0];
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w. Two instances run in lockstep:
// dut0 with defaults (zero register + bypass), dut1 with both disabled.
module tb_reg_file_2r1w;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_file_2r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
    reg_file_2r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // driver tasks: all drives happen 2 time units after a rising edge
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input logic [3:0] a, input logic [3:0] b);
        bus0.rd_addr_a = a; bus0.rd_addr_b = b;
        bus1.rd_addr_a = a; bus1.rd_addr_b = b;
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [3:0] addr, input logic [31:0] data);
        bus0.wr_en = en; bus0.wr_addr = addr; bus0.wr_data = data;
        bus1.wr_en = en; bus1.wr_addr = addr; bus1.wr_data = data;
    endtask

    task automatic write(input logic [3:0] addr, input logic [31:0] data);
        set_wr(1'b1, addr, data);
        next_cycle();
        set_wr(1'b0, 4'd0, 32'd0);
    endtask

    // Release reset off-edge and count edges until ready, checking each one.
    task automatic release_and_count(input string tag);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            #1;
            check({tag, "_ready"}, {31'd0, bus0.ready}, {31'd0, (i == 16)});
            check({tag, "_ready1"}, {31'd0, bus1.ready}, {31'd0, (i == 16)});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        set_wr(1'b0, 4'd0, 32'd0);
        set_rd(4'd5, 4'd15);

        // ---- clear sequence ----
        #2 rst_n = 1'b0;
        #20;
        check("rst_ready", {31'd0, bus0.ready}, 32'd0);
        check("rst_wr_drop", {31'd0, bus0.wr_drop}, 32'd0);
        check("rst_state", {31'd0, bus0.dbg_state}, 32'd0);
        check("rst_rd_a", bus0.rd_data_a, 32'd0);
        check("rst_rd_b", bus1.rd_data_b, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("clr_ready0", {31'd0, bus0.ready}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            #1;
            check("clr_ready", {31'd0, bus0.ready}, {31'd0, (i == 16)});
            check("clr_rd_a5", bus0.rd_data_a, 32'd0);
            check("clr_rd_b15", bus0.rd_data_b, 32'd0);
            check("clr_rd1_a5", bus1.rd_data_a, 32'd0);
        end
        check("run_state", {31'd0, bus0.dbg_state}, 32'd1);
        check("run_ready1", {31'd0, bus1.ready}, 32'd1);

        // ---- dual read and write ----
        write(4'd3, 32'hDEADBEEF);
        write(4'd7, 32'h12345678);
        set_rd(4'd3, 4'd7);
        check("dual_a", bus0.rd_data_a, 32'hDEADBEEF);
        check("dual_b", bus0.rd_data_b, 32'h12345678);
        check("dual1_a", bus1.rd_data_a, 32'hDEADBEEF);
        check("dual1_b", bus1.rd_data_b, 32'h12345678);
        set_rd(4'd7, 4'd3);
        check("swap_a", bus0.rd_data_a, 32'h12345678);
        check("swap_b", bus0.rd_data_b, 32'hDEADBEEF);

        // ---- zero register ----
        write(4'd0, 32'hFFFFFFFF);
        set_rd(4'd0, 4'd0);
        check("zero_a", bus0.rd_data_a, 32'h0);
        check("zero_b", bus0.rd_data_b, 32'h0);
        check("zero_drop", {31'd0, bus0.wr_drop}, 32'd0);
        check("nozero_a", bus1.rd_data_a, 32'hFFFFFFFF);
        check("nozero_b", bus1.rd_data_b, 32'hFFFFFFFF);
        check("nozero_drop", {31'd0, bus1.wr_drop}, 32'd0);

        // ---- bypass ----
        write(4'd9, 32'h11111111);
        set_wr(1'b1, 4'd9, 32'hCAFEF00D);
        set_rd(4'd9, 4'd9);
        check("byp_a", bus0.rd_data_a, 32'hCAFEF00D);
        check("byp_b", bus0.rd_data_b, 32'hCAFEF00D);
        check("nobyp_a", bus1.rd_data_a, 32'h11111111);
        check("nobyp_b", bus1.rd_data_b, 32'h11111111);
        next_cycle();
        set_wr(1'b0, 4'd0, 32'd0);
        #1;
        check("byp_after_a", bus0.rd_data_a, 32'hCAFEF00D);
        check("nobyp_after_a", bus1.rd_data_a, 32'hCAFEF00D);
        check("nobyp_after_b", bus1.rd_data_b, 32'hCAFEF00D);

        // ---- reset mid-operation ----
        for (int i = 1; i < 16; i++) begin
            write(4'(i), 32'hA5000000 + 32'(i));
        end
        set_rd(4'd15, 4'd1);
        check("fill_a15", bus0.rd_data_a, 32'hA500000F);
        check("fill_b1", bus0.rd_data_b, 32'hA5000001);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_ready", {31'd0, bus0.ready}, 32'd0);
        check("mid_rd_a", bus0.rd_data_a, 32'd0);
        @(posedge clk); #2;
        release_and_count("mid");
        for (int i = 0; i < 16; i++) begin
            set_rd(4'(i), 4'(15 - i));
            check("mid_clr_a", bus0.rd_data_a, 32'd0);
            check("mid_clr_b", bus0.rd_data_b, 32'd0);
            check("mid_clr1_a", bus1.rd_data_a, 32'd0);
        end
        check("mid_drop", {31'd0, bus0.wr_drop}, 32'd0);

        // ---- write during clear ----
        rst_n = 1'b0;
        #10;
        @(posedge clk); #2;
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        set_wr(1'b1, 4'd4, 32'hAAAA5555);
        next_cycle();
        set_wr(1'b0, 4'd0, 32'd0);
        #1;
        check("wdc_drop", {31'd0, bus0.wr_drop}, 32'd1);
        check("wdc_drop1", {31'd0, bus1.wr_drop}, 32'd1);
        begin
            int n;
            n = 0;
            while (!bus0.ready && n < 40) begin
                next_cycle();
                n++;
            end
            check("wdc_ready_timeout", {31'd0, bus0.ready}, 32'd1);
        end
        set_rd(4'd4, 4'd4);
        check("wdc_e4_a", bus0.rd_data_a, 32'd0);
        check("wdc_e4_b1", bus1.rd_data_b, 32'd0);
        write(4'd4, 32'h0BADF00D);
        set_rd(4'd4, 4'd2);
        check("wdc_e4_wr", bus0.rd_data_a, 32'h0BADF00D);
        check("wdc_sticky", {31'd0, bus0.wr_drop}, 32'd1);
        check("wdc_sticky1", {31'd0, bus1.wr_drop}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("wdc_drop_rst", {31'd0, bus0.wr_drop}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
